// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - edge-latched interrupt arbiter/sequencer feeding jump control (vector 0xF0).
// Optional round-robin winner selection under IRQ_ROUND_ROBIN_EN; fixed lowest-index priority otherwise.
module irq_scheduler #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               int_en,
  input  logic [23:0]        ins,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic               irq_active,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_ISR, S_GUARD} state_t;

  localparam logic [4:0] OP_RET = 5'b10000;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [ID_W-1:0]    r_id;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_clr;
  logic [ID_W-1:0]    w_win;
  logic               w_grant_ok;
  logic               w_grant;
  logic               w_is_ret;
  logic               w_unused;

  assign w_rise     = irq_req & ~r_prev;
  assign w_elig     = r_pending & ~irq_mask;
  // Entry is withheld while a jump/RET sits in decode so it never races a taken branch.
  assign w_grant_ok = int_en & (|w_elig) & ~ins[23];
  assign w_is_ret   = (ins[23:19] == OP_RET);
  assign w_unused   = ^ins[18:0];

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_last;

  always_comb begin
    int idx;
    w_win = '0;
    for (int k = NUM_IRQ; k >= 1; k--) begin
      idx = (int'(r_last) + k) % NUM_IRQ;
      if (w_elig[idx]) w_win = ID_W'(idx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_last <= ID_W'(NUM_IRQ - 1);
    else if (w_grant) r_last <= w_win;
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_prev    <= '0;
      r_pending <= '0;
      r_id      <= '0;
    end else begin
      r_state   <= w_next;
      r_prev    <= irq_req;
      // A fresh edge on the line being granted survives the clear.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_grant) r_id <= w_win;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_clr      = '0;
    interrupt  = 1'b0;
    irq_active = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_ok) begin
          w_grant = 1'b1;
          w_clr   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << w_win;
          w_next  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        interrupt  = 1'b1;
        irq_active = 1'b1;
        w_next     = S_ISR;
      end
      S_ISR: begin
        irq_active = 1'b1;
        if (w_is_ret) w_next = S_GUARD;
      end
      S_GUARD: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign irq_id      = r_id;
  assign irq_pending = r_pending;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - directed self-checking bench for irq_scheduler (default fixed-priority build).
module tb_irq_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_req;
  logic [3:0]  irq_mask;
  logic        int_en;
  logic [23:0] ins;
  logic        interrupt;
  logic [1:0]  irq_id;
  logic        irq_active;
  logic [3:0]  irq_pending;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [23:0] INS_NOP = 24'h000000;
  localparam logic [23:0] INS_JMP = 24'hC00000;
  localparam logic [23:0] INS_RET = 24'h800000;

  irq_scheduler #(.NUM_IRQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_req    (irq_req),
    .irq_mask   (irq_mask),
    .int_en     (int_en),
    .ins        (ins),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .irq_active (irq_active),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    irq_req  = 4'b0000;
    irq_mask = 4'b0000;
    int_en   = 1'b1;
    ins      = INS_NOP;
    step();
    step();
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_active", 32'(irq_active), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(irq_pending), 32'd0);
    reset = 1'b1;
    step();

    // Single request on line 2
    irq_req = 4'b0100;
    step();
    check("t1_pending_set", 32'(irq_pending), 32'h4);
    check("t1_no_int_yet", 32'(interrupt), 32'd0);
    irq_req = 4'b0000;
    step();
    check("t1_interrupt", 32'(interrupt), 32'd1);
    check("t1_id", 32'(irq_id), 32'd2);
    check("t1_pending_clr", 32'(irq_pending), 32'd0);
    check("t1_active", 32'(irq_active), 32'd1);
    step();
    check("t1_pulse_one_cycle", 32'(interrupt), 32'd0);
    check("t1_active_isr", 32'(irq_active), 32'd1);

    // JMP in ISR keeps it active, RET leads through GUARD to IDLE
    ins = INS_JMP;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_active_jmp", 32'(irq_active), 32'd1);
    end
    ins = INS_RET;
    step();
    check("t2_guard_inactive", 32'(irq_active), 32'd0);
    ins = INS_NOP;
    step();
    check("t2_idle_inactive", 32'(irq_active), 32'd0);
    check("t2_idle_no_int", 32'(interrupt), 32'd0);

    // Simultaneous lines 0 and 3: 0 first, 3 one cycle after IDLE
    irq_req = 4'b1001;
    step();
    check("t3_pending_both", 32'(irq_pending), 32'h9);
    step();
    check("t3_int0", 32'(interrupt), 32'd1);
    check("t3_id0", 32'(irq_id), 32'd0);
    check("t3_pending3", 32'(irq_pending), 32'h8);
    ins = INS_RET;
    step();
    check("t3_isr_no_int", 32'(interrupt), 32'd0);
    step();
    check("t3_guard_no_int", 32'(interrupt), 32'd0);
    check("t3_guard_inactive", 32'(irq_active), 32'd0);
    ins = INS_NOP;
    step();
    check("t3_idle_no_int", 32'(interrupt), 32'd0);
    check("t3_idle_pending3", 32'(irq_pending), 32'h8);
    step();
    check("t3_int3", 32'(interrupt), 32'd1);
    check("t3_id3", 32'(irq_id), 32'd3);
    check("t3_pending_empty", 32'(irq_pending), 32'd0);
    step();
    ins = INS_RET;
    irq_req = 4'b0000;
    step();
    ins = INS_NOP;
    step();

    // Masked line 1 accumulates, repeated edges collapse, granted after unmask
    irq_mask = 4'b0010;
    irq_req  = 4'b0010;
    step();
    check("t4_masked_pending", 32'(irq_pending), 32'h2);
    irq_req = 4'b0000;
    step();
    irq_req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_masked_no_int", 32'(interrupt), 32'd0);
    end
    irq_req = 4'b0000;
    step();
    check("t4_pending_held", 32'(irq_pending), 32'h2);
    irq_mask = 4'b0000;
    step();
    check("t4_unmask_int", 32'(interrupt), 32'd1);
    check("t4_unmask_id", 32'(irq_id), 32'd1);
    check("t4_collapsed", 32'(irq_pending), 32'd0);
    step();
    ins = INS_RET;
    step();
    ins = INS_NOP;
    step();

    // RET/jump opcode in decode blocks entry (and RET is ignored in IDLE)
    ins     = INS_RET;
    irq_req = 4'b0010;
    step();
    check("t5_pending", 32'(irq_pending), 32'h2);
    check("t5_block1", 32'(interrupt), 32'd0);
    step();
    check("t5_block2", 32'(interrupt), 32'd0);
    check("t5_idle_inactive", 32'(irq_active), 32'd0);
    ins = INS_NOP;
    step();
    check("t5_int", 32'(interrupt), 32'd1);
    check("t5_id", 32'(irq_id), 32'd1);
    int_en = 1'b0;
    step();
    step();
    check("t5_int_en_drop_keeps_isr", 32'(irq_active), 32'd1);

    // Async reset mid-ISR with line 3 pending
    int_en  = 1'b1;
    irq_req = 4'b1000;
    step();
    check("t6_pending3", 32'(irq_pending), 32'h8);
    check("t6_in_isr", 32'(irq_active), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_active", 32'(irq_active), 32'd0);
    check("t6_rst_pending", 32'(irq_pending), 32'd0);
    check("t6_rst_int", 32'(interrupt), 32'd0);
    irq_req = 4'b0000;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_post_rst_no_int", 32'(interrupt), 32'd0);
    end
    check("t6_post_rst_pending", 32'(irq_pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
